// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, transmitter state encoding and the
// nibble-to-ASCII helper used to build register-report frames.
package uart_pkg;

    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_COLON = 8'h3A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'
    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        logic [7:0] ch;
        ch = 8'h30 + 8'(nib);
        if (nib > 4'd9) begin
            ch = 8'h41 + 8'(nib) - 8'd10;
        end
        return ch;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with baud counter. A byte offered during the final stop-bit
// cycle is chained straight into the next start bit, so there is no inter-byte gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready_c,
    output logic       byte_done_c,
    output logic       tx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_end_c;

    always_comb begin
        bit_end_c    = (cnt == CNT_MAX);
        byte_done_c  = (state == ST_STOP) && bit_end_c;
        byte_ready_c = (state == ST_IDLE) || byte_done_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    tx  <= 1'b1;
                    if (byte_valid) begin
                        shift <= byte_data;
                        state <= ST_START;
                        tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_c) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                        tx      <= shift[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_c) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_c) begin
                        cnt <= '0;
                        if (byte_valid) begin
                            shift <= byte_data;
                            state <= ST_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_reg_reporter.sv
// Register-report frame sequencer: captures (idx, data) and streams
// CR 'R' idx ':' d3 d2 d1 d0 LF through the byte serializer.
module uart_reg_reporter
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_idx,
    input  logic [15:0] req_data,
    output logic        tx,
    output logic        busy
);

    localparam logic [3:0] LAST_BYTE = 4'd8;

    logic [3:0]  cap_idx;
    logic [15:0] cap_data;
    logic [3:0]  byte_idx;
    logic [3:0]  next_idx_c;
    logic        byte_valid_c;
    logic [7:0]  byte_data_c;
    logic        byte_ready_c;
    logic        byte_done_c;
    logic        byte_fire_c;

    function automatic logic [7:0] frame_byte(input logic [3:0]  sel,
                                              input logic [3:0]  idx,
                                              input logic [15:0] data);
        logic [7:0] b;
        b = LF;
        case (sel)
            4'd0: b = CR;
            4'd1: b = CH_R;
            4'd2: b = hex2ascii(idx);
            4'd3: b = CH_COLON;
            4'd4: b = hex2ascii(data[15:12]);
            4'd5: b = hex2ascii(data[11:8]);
            4'd6: b = hex2ascii(data[7:4]);
            4'd7: b = hex2ascii(data[3:0]);
            default: b = LF;
        endcase
        return b;
    endfunction

    // While idle, byte 0 (CR) is offered on the accept edge so the start bit follows immediately
    always_comb begin
        next_idx_c   = byte_idx + 4'd1;
        byte_valid_c = 1'b0;
        byte_data_c  = CR;
        if (req_ready) begin
            byte_valid_c = req_valid;
        end else begin
            byte_valid_c = (byte_idx != LAST_BYTE);
            byte_data_c  = frame_byte(next_idx_c, cap_idx, cap_data);
        end
        byte_fire_c = byte_valid_c && byte_ready_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            cap_idx   <= '0;
            cap_data  <= '0;
            byte_idx  <= '0;
        end else if (req_ready) begin
            if (req_valid) begin
                cap_idx   <= req_idx;
                cap_data  <= req_data;
                byte_idx  <= '0;
                req_ready <= 1'b0;
                busy      <= 1'b1;
            end
        end else if (byte_fire_c) begin
            byte_idx <= next_idx_c;
        end else if (byte_done_c) begin
            byte_idx  <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid   (byte_valid_c),
        .byte_data    (byte_data_c),
        .byte_ready_c (byte_ready_c),
        .byte_done_c  (byte_done_c),
        .tx           (tx)
    );

endmodule

// File: tb/tb_uart_reg_reporter.sv
// Directed bench for uart_reg_reporter: a UART receiver model decodes tx and
// checks each byte against a queue of expected frame bytes.
module tb_uart_reg_reporter;

    localparam int unsigned CPB       = 8;
    localparam int unsigned FRAME_CYC = 90 * CPB;
    localparam int unsigned LIMIT     = 200 * CPB;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_idx   = 4'h0;
    logic [15:0] req_data  = 16'h0000;
    logic        req_ready;
    logic        tx;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    uart_reg_reporter #(
        .CLK_FREQ     (100_000_000),
        .BAUD         (115200),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_data  (req_data),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

    task automatic push_frame(input logic [3:0] i, input logic [15:0] d);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h52);
        exp_q.push_back(hexc(i));
        exp_q.push_back(8'h3A);
        exp_q.push_back(hexc(d[15:12]));
        exp_q.push_back(hexc(d[11:8]));
        exp_q.push_back(hexc(d[7:4]));
        exp_q.push_back(hexc(d[3:0]));
        exp_q.push_back(8'h0A);
    endtask

    // Returns #1 after the accept edge
    task automatic send(input logic [3:0] i, input logic [15:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_idx   = i;
        req_data  = d;
        @(posedge clk);
        #1;
        push_frame(i, d);
        check("accept_ready_low", 32'(req_ready), 32'd0);
        check("accept_busy_high", 32'(busy), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n, input int start);
        n = start;
        while (!req_ready && n < int'(LIMIT)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) check("idle_timeout", 32'(req_ready), 32'd1);
    endtask

    // Receiver model: samples every cycle on negedge, each slot must be stable
    initial begin : rx_model
        logic [7:0] b;
        logic [7:0] e;
        logic       framing_ok;
        logic       aborted;
        logic       v;
        string      line;
        line = "";
        v    = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                framing_ok = 1'b1;
                aborted    = 1'b0;
                b          = 8'h00;
                for (int s = 0; s < 10 && !aborted; s++) begin
                    for (int k = 0; k < int'(CPB) && !aborted; k++) begin
                        if (!(s == 0 && k == 0)) @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                        end else begin
                            if (k == 0) v = tx;
                            if (tx !== v) framing_ok = 1'b0;
                            if (s == 0 && tx !== 1'b0) framing_ok = 1'b0;
                            if (s == 9 && tx !== 1'b1) framing_ok = 1'b0;
                            if (k == 0 && s >= 1 && s <= 8) b[s-1] = tx;
                        end
                    end
                end
                if (aborted) begin
                    line = "";
                end else begin
                    check("rx_framing", 32'(framing_ok), 32'd1);
                    check("rx_byte_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rx_byte", 32'(b), 32'(e));
                    end
                    if (b == 8'h0D) line = "";
                    else if (b == 8'h0A) $display("RX line: %s", line);
                    else line = $sformatf("%s%c", line, b);
                end
            end
        end
    end

    initial begin : stim
        int   n;
        logic bad [10];
        logic [7:0] cr;
        logic expb;
        cr = 8'h0D;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_tx", 32'(tx), 32'd1);

        // Frame 1 with cycle-exact bit timing of the leading CR
        send(4'h3, 16'hBEEF);
        for (int s = 0; s < 10; s++) bad[s] = 1'b0;
        for (int k = 0; k < int'(10 * CPB); k++) begin
            int s;
            s = k / int'(CPB);
            expb = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : cr[s-1];
            if (tx !== expb) bad[s] = 1'b1;
            @(posedge clk);
            #1;
        end
        for (int s = 0; s < 10; s++) check($sformatf("cr_bit_slot%0d", s), 32'(bad[s]), 32'd0);
        wait_idle(n, int'(10 * CPB));
        check("frame1_len", 32'(n), 32'(FRAME_CYC));
        repeat (4) @(posedge clk);

        // Encoding edge, input changed one cycle after acceptance
        send(4'hA, 16'h0009);
        @(posedge clk);
        #1;
        req_idx  = 4'hF;
        req_data = 16'h1234;
        wait_idle(n, 1);
        check("frame2_len", 32'(n), 32'(FRAME_CYC));
        repeat (4) @(posedge clk);

        send(4'h0, 16'hFFFF);
        wait_idle(n, 0);
        check("frame3_len", 32'(n), 32'(FRAME_CYC));
        repeat (4) @(posedge clk);

        // Back-to-back: second request held high mid-frame
        send(4'h1, 16'h1111);
        repeat (100) @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_idx   = 4'h2;
        req_data  = 16'h2222;
        check("b2b_mid_ready", 32'(req_ready), 32'd0);
        wait_idle(n, 100);
        check("b2b_first_len", 32'(n), 32'(FRAME_CYC));
        push_frame(4'h2, 16'h2222);
        @(posedge clk);
        #1;
        check("b2b_reaccept_ready", 32'(req_ready), 32'd0);
        check("b2b_start_bit", 32'(tx), 32'd0);
        req_valid = 1'b0;
        wait_idle(n, 0);
        check("b2b_second_len", 32'(n), 32'(FRAME_CYC));
        repeat (4) @(posedge clk);

        // Reset during byte 4
        send(4'h5, 16'h5A5A);
        repeat (40 * CPB + CPB / 2) @(posedge clk);
        check("prereset_pending", 32'(exp_q.size()), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_ready", 32'(req_ready), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        send(4'hC, 16'h0123);
        wait_idle(n, 0);
        check("postreset_len", 32'(n), 32'(FRAME_CYC));
        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
